calc_sequencer: RTL
===================

// Module: calc_sequencer
// PURPOSE
//  Sequences one calculator operation at a time over the shared datapath.
//  The datapath is a single-cycle adder/subtractor, an iterative multiplier and an iterative divider.
//  Decodes the 3-bit funct, selects operand A (new input or stored previous result), drives
//  sub/start controls, waits on multi-cycle units, and writes the result back to the prev register.
//  Sits between the keypad/command front end and the arithmetic units.
// PARAMETERS
//  W        16   operand/result width (two's complement)
//  MAX_WAIT 64   cycles allowed for mult_done/div_done before timeout error
// PORTS
//  clk          in   1  system clock, rising edge
//  reset_n      in   1  asynchronous active-low reset
//  op_valid     in   1  command present
//  op_ready     out  1  sequencer can accept (high only in IDLE)
//  funct        in   3  000 ADD,001 SUB,010 MULT,011 DIV,1xx same op with A=prev
//  opnd_a       in   W  operand A (ignored when funct[2]=1)
//  opnd_b       in   W  operand B
//  clr_prev     in   1  synchronous clear of prev register (IDLE only)
//  alu_a,alu_b  out  W  operands to all units, held stable from EXEC until DONE
//  alu_sub      out  1  1=subtract (SUB), 0=add
//  alu_result   in   W  adder/subtractor output, combinational
//  mult_start   out  1  one-cycle start pulse
//  mult_done    in   1  multiplier finished; mult_result valid this cycle
//  mult_result  in   W  low W bits of product
//  div_start    out  1  one-cycle start pulse
//  div_done     in   1  divider finished; div_result valid this cycle
//  div_result   in   W  quotient
//  result       out  W  last result, held until next DONE
//  result_valid out  1  one-cycle pulse per completed command
//  err          out  2  00 ok, 01 divide-by-zero, 10 timeout; valid with result_valid
//  prev_value   out  W  stored previous result
// BEHAVIOUR
//  Reset: state=IDLE; op_ready=1, all other outputs 0 (prev_value=0, result=0, err=00).
//  States: IDLE, EXEC, WAIT_M, WAIT_D, DONE.
//  IDLE: on op_valid&op_ready, latch funct, A (funct[2] ? prev_value : opnd_a), B; go EXEC.
//        clr_prev in IDLE without accept -> prev_value=0 next cycle; with accept, the accept uses
//        the old prev and the clear still applies.
//  EXEC (1 cycle): ADD/SUB -> capture alu_result, go DONE.
//        MULT -> mult_start=1, clear wait counter, go WAIT_M.
//        DIV, B==0 -> no div_start, result=all-ones, err=01, go DONE.
//        DIV, B!=0 -> div_start=1, go WAIT_D.
//  WAIT_M/WAIT_D: counter increments each cycle. Done is sampled only in these states;
//        a done asserted during EXEC is ignored.
//        On done: capture the unit result, go DONE.
//        If counter reaches MAX_WAIT-1 without done: result=0, err=10, go DONE.
//  DONE (1 cycle): result_valid=1. If err==00, prev_value<=result; otherwise prev is unchanged.
//        Go IDLE; op_ready returns next cycle.
//  Latency accept->result_valid: ADD/SUB/DIV0 = 2 cycles; MULT/DIV = 3 + unit latency.
//  Throughput: one command in flight; op_ready=0 from EXEC through DONE.
//  Arithmetic: wrap modulo 2^W; overflow is not flagged.
//  Reset mid-operation: immediate return to IDLE, starts deasserted, prev cleared.
//    Any later done from a unit is ignored.
// TESTING
//  ADD 5+7 from reset -> result_valid 2 cycles after accept, result=12, prev_value=12, err=00
//  Then funct=101 (SUBToPrev), B=20 -> alu_a=12, alu_sub=1, result=-8 (0xFFF8), prev=0xFFF8
//  MULT 300*3 with a model asserting mult_done 5 cycles after start -> one mult_start pulse,
//    result=900, result_valid 8 cycles after accept
//  DIV 100/0 -> no div_start, result=0xFFFF, err=01, prev unchanged
//  DIV with div_done never asserted -> err=10 exactly MAX_WAIT cycles after div_start; op_ready returns
//  reset_n low during WAIT_M, then model pulses mult_done -> IDLE, no result_valid, prev=0

Source files
------------

// File: rtl/calc_sequencer.sv
// Calculator command sequencer: decodes one command at a time, steers operands to the shared
// add/sub, multiplier and divider units, waits on the iterative units and keeps the previous result.
//
// state  | meaning
// IDLE   | waiting for a command; op_ready high; clr_prev honoured
// EXEC   | operands latched; add/sub captured or multi-cycle unit launched
// WAIT_M | waiting for mult_done, bounded by the wait timer
// WAIT_D | waiting for div_done, bounded by the wait timer
// DONE   | result_valid pulse; prev updated on error-free completion
module calc_sequencer #(
   parameter int W        = 16,
   parameter int MAX_WAIT = 64
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         op_valid,
   output logic         op_ready,
   input  logic [2:0]   funct,
   input  logic [W-1:0] opnd_a,
   input  logic [W-1:0] opnd_b,
   input  logic         clr_prev,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic         alu_sub,
   input  logic [W-1:0] alu_result,
   output logic         mult_start,
   input  logic         mult_done,
   input  logic [W-1:0] mult_result,
   output logic         div_start,
   input  logic         div_done,
   input  logic [W-1:0] div_result,
   output logic [W-1:0] result,
   output logic         result_valid,
   output logic [1:0]   err,
   output logic [W-1:0] prev_value
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] EXEC   = 3'd1;
   localparam logic [2:0] WAIT_M = 3'd2;
   localparam logic [2:0] WAIT_D = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_MULT = 2'b10;
   localparam logic [1:0] OP_DIV  = 2'b11;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_DIV0 = 2'b01;
   localparam logic [1:0] ERR_TOUT = 2'b10;

   localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CW-1:0] TC_LOAD = CW'(MAX_WAIT - 1);

   logic [2:0]    state;
   logic [1:0]    op_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [CW-1:0] wait_cnt;

   assign op_ready     = (state == IDLE);
   assign result_valid = (state == DONE);
   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_sub      = (op_q == OP_SUB);

   // Start pulses are registered, so they appear in the first wait-state cycle and the
   // wait timer counts from that same cycle: a hung unit times out MAX_WAIT cycles after start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         op_q       <= OP_ADD;
         a_q        <= '0;
         b_q        <= '0;
         wait_cnt   <= '0;
         mult_start <= 1'b0;
         div_start  <= 1'b0;
         result     <= '0;
         err        <= ERR_OK;
         prev_value <= '0;
      end else begin
         mult_start <= 1'b0;
         div_start  <= 1'b0;
         case (state)
            IDLE: begin
               if (op_valid) begin
                  op_q  <= funct[1:0];
                  a_q   <= funct[2] ? prev_value : opnd_a;
                  b_q   <= opnd_b;
                  state <= EXEC;
               end
               if (clr_prev) begin
                  prev_value <= '0;
               end
            end
            EXEC: begin
               case (op_q)
                  OP_ADD, OP_SUB: begin
                     result <= alu_result;
                     err    <= ERR_OK;
                     state  <= DONE;
                  end
                  OP_MULT: begin
                     mult_start <= 1'b1;
                     wait_cnt   <= TC_LOAD;
                     state      <= WAIT_M;
                  end
                  default: begin
                     if (b_q == '0) begin
                        result <= '1;
                        err    <= ERR_DIV0;
                        state  <= DONE;
                     end else begin
                        div_start <= 1'b1;
                        wait_cnt  <= TC_LOAD;
                        state     <= WAIT_D;
                     end
                  end
               endcase
            end
            WAIT_M: begin
               if (mult_done) begin
                  result <= mult_result;
                  err    <= ERR_OK;
                  state  <= DONE;
               end else if (wait_cnt == '0) begin
                  result <= '0;
                  err    <= ERR_TOUT;
                  state  <= DONE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            WAIT_D: begin
               if (div_done) begin
                  result <= div_result;
                  err    <= ERR_OK;
                  state  <= DONE;
               end else if (wait_cnt == '0) begin
                  result <= '0;
                  err    <= ERR_TOUT;
                  state  <= DONE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            DONE: begin
               if (err == ERR_OK) begin
                  prev_value <= result;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
